ace_snoop_responder: RTL and testbench



---
 rtl/ace_snoop_responder.sv | 128 ++++++++++++
 tb/tb_ace_snoop_responder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ace_snoop_responder.sv
// ace_snoop_responder: ACE snoop responder (AC -> dcache lookup -> CR/CD); optional SNOOP_CRITICAL_WORD_FIRST_EN
module ace_snoop_responder #(
  parameter int AW         = 64,
  parameter int DW         = 64,
  parameter int LINE_BYTES = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    ac_valid_i,
  output logic                    ac_ready_o,
  input  logic [AW-1:0]           ac_addr_i,
  input  logic [3:0]              ac_snoop_i,
  input  logic [2:0]              ac_prot_i,
  output logic                    cr_valid_o,
  input  logic                    cr_ready_i,
  output logic [4:0]              cr_resp_o,
  output logic                    cd_valid_o,
  input  logic                    cd_ready_i,
  output logic [DW-1:0]           cd_data_o,
  output logic                    cd_last_o,
  output logic                    lookup_req_o,
  input  logic                    lookup_gnt_i,
  output logic [AW-1:0]           lookup_addr_o,
  output logic                    lookup_inv_o,
  output logic                    lookup_clean_o,
  input  logic                    lookup_valid_i,
  input  logic                    lookup_hit_i,
  input  logic                    lookup_dirty_i,
  input  logic                    lookup_shared_i,
  input  logic [LINE_BYTES*8-1:0] lookup_data_i,
  output logic                    busy_o
);
  localparam int BEATS = LINE_BYTES * 8 / DW;
  localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int WOFF  = $clog2(DW / 8);
  localparam logic [2:0] IDLE = 3'd0, LOOKUP = 3'd1, WAIT = 3'd2, RESP = 3'd3, DATA = 3'd4;
  logic [2:0]              state_q, state_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic [3:0]              snoop_q, snoop_d;
  logic [4:0]              resp_q, resp_d;
  logic [LINE_BYTES*8-1:0] data_q, data_d;
  logic [BW-1:0]           beat_q, beat_d, cnt_q, cnt_d, start;
  logic ro, rs, ru, ci, cs, mi, sup_in, dt, is, pd, last, unused_prot;
  assign ro = snoop_q == 4'b0000;
  assign rs = snoop_q inside {4'b0001, 4'b0010, 4'b0011};
  assign ru = snoop_q == 4'b0111;
  assign ci = snoop_q == 4'b1001;
  assign cs = snoop_q == 4'b1000;
  assign mi = snoop_q == 4'b1101;
  assign sup_in = ac_snoop_i inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111, 4'b1001, 4'b1000, 4'b1101};
  assign dt = ro | rs | ru | ((ci | cs) & lookup_dirty_i);
  assign is = ro | rs | cs;
  assign pd = (rs | ru | ci | cs) & lookup_dirty_i;
  assign last = cnt_q == BW'(BEATS - 1);
  assign unused_prot = ^ac_prot_i;
`ifdef SNOOP_CRITICAL_WORD_FIRST_EN
  assign start = BW'((addr_q >> WOFF) % AW'(BEATS));
`else
  assign start = '0;
`endif
  // Handshakes are gated by reset so a reset cycle shows no valid/ready/request
  assign ac_ready_o     = (state_q == IDLE) & ~rst_i;
  assign lookup_req_o   = (state_q == LOOKUP) & ~rst_i;
  assign lookup_inv_o   = lookup_req_o & (ru | ci | mi);
  assign lookup_clean_o = lookup_req_o & (rs | cs);
  assign lookup_addr_o  = addr_q & ~AW'(LINE_BYTES - 1);
  assign cr_valid_o     = (state_q == RESP) & ~rst_i;
  assign cr_resp_o      = resp_q;
  assign cd_valid_o     = (state_q == DATA) & ~rst_i;
  assign cd_last_o      = cd_valid_o & last;
  assign cd_data_o      = data_q[int'(beat_q)*DW +: DW];
  assign busy_o         = state_q != IDLE;
  // Next-state and datapath for the single outstanding snoop
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    snoop_d = snoop_q;
    resp_d  = resp_q;
    data_d  = data_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (ac_valid_i) begin
        addr_d  = ac_addr_i;
        snoop_d = ac_snoop_i;
        resp_d  = '0;
        state_d = sup_in ? LOOKUP : RESP;
      end
      LOOKUP: state_d = lookup_gnt_i ? WAIT : LOOKUP;
      WAIT: if (lookup_valid_i) begin
        data_d  = lookup_data_i;
        resp_d  = lookup_hit_i ? {~lookup_shared_i, is, pd, 1'b0, dt} : 5'b0;
        state_d = RESP;
      end
      RESP: if (cr_ready_i) begin
        beat_d  = start;
        cnt_d   = '0;
        state_d = resp_q[0] ? DATA : IDLE;
      end
      DATA: if (cd_ready_i) begin
        beat_d  = (beat_q == BW'(BEATS - 1)) ? '0 : beat_q + 1'b1;
        cnt_d   = cnt_q + 1'b1;
        state_d = last ? IDLE : DATA;
      end
      default: state_d = IDLE;
    endcase
  end
  // State registers with synchronous reset discarding any in-flight snoop
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      snoop_q <= '0;
      resp_q  <= '0;
      data_q  <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      snoop_q <= snoop_d;
      resp_q  <= resp_d;
      data_q  <= data_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_ace_snoop_responder.sv
// tb_ace_snoop_responder: directed self-checking bench for ace_snoop_responder
module tb_ace_snoop_responder;
  localparam logic [63:0] LO = 64'h2222_2222_2222_2222;
  localparam logic [63:0] HI = 64'h1111_1111_1111_1111;
  logic clk = 0, rst = 1;
  logic ac_valid = 0, cr_ready = 0, cd_ready = 0;
  logic [63:0] ac_addr = 0;
  logic [3:0] ac_snoop = 0;
  logic [2:0] ac_prot = 0;
  logic lk_gnt = 0, lk_valid = 0, lk_hit = 0, lk_dirty = 0, lk_shared = 0;
  logic [127:0] lk_data = 0;
  logic ac_ready, cr_valid, cd_valid, cd_last, lk_req, lk_inv, lk_clean, busy;
  logic [4:0] cr_resp;
  logic [63:0] cd_data, lk_addr;
  int tests = 0, fails = 0;

  ace_snoop_responder dut (
    .clk_i(clk), .rst_i(rst),
    .ac_valid_i(ac_valid), .ac_ready_o(ac_ready), .ac_addr_i(ac_addr), .ac_snoop_i(ac_snoop), .ac_prot_i(ac_prot),
    .cr_valid_o(cr_valid), .cr_ready_i(cr_ready), .cr_resp_o(cr_resp),
    .cd_valid_o(cd_valid), .cd_ready_i(cd_ready), .cd_data_o(cd_data), .cd_last_o(cd_last),
    .lookup_req_o(lk_req), .lookup_gnt_i(lk_gnt), .lookup_addr_o(lk_addr),
    .lookup_inv_o(lk_inv), .lookup_clean_o(lk_clean), .lookup_valid_i(lk_valid),
    .lookup_hit_i(lk_hit), .lookup_dirty_i(lk_dirty), .lookup_shared_i(lk_shared),
    .lookup_data_i(lk_data), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_ac(input logic [63:0] a, input logic [3:0] s);
    ac_valid = 1; ac_addr = a; ac_snoop = s;
    tick();
    ac_valid = 0;
  endtask

  task automatic do_lookup(input logic h, input logic d, input logic sh);
    lk_gnt = 1;
    tick();
    lk_gnt = 0; lk_valid = 1; lk_hit = h; lk_dirty = d; lk_shared = sh; lk_data = {HI, LO};
    tick();
    lk_valid = 0;
  endtask

  task automatic test_reset();
    tick();
    tests++; if ({ac_ready, busy, cr_valid, cd_valid, lk_req} !== 5'b0) begin fails++; $display("FAIL reset_outputs got %b exp 00000", {ac_ready, busy, cr_valid, cd_valid, lk_req}); end
    rst = 0;
    tick();
    tests++; if (ac_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready got %b exp 1", ac_ready); end
  endtask

  task automatic test_read_shared();
    logic [63:0] first, second;
`ifdef SNOOP_CRITICAL_WORD_FIRST_EN
    first = HI; second = LO;
`else
    first = LO; second = HI;
`endif
    send_ac(64'h8000_0018, 4'b0001);
    tests++; if ({lk_req, lk_clean, lk_inv, ac_ready, busy} !== 5'b11001) begin fails++; $display("FAIL rs_lookup_ctl got %b exp 11001", {lk_req, lk_clean, lk_inv, ac_ready, busy}); end
    tests++; if (lk_addr !== 64'h8000_0010) begin fails++; $display("FAIL rs_lookup_addr got %h exp 8000_0010", lk_addr); end
    tick();
    tests++; if (lk_req !== 1'b1 || lk_addr !== 64'h8000_0010) begin fails++; $display("FAIL rs_lookup_hold got %b/%h exp 1/8000_0010", lk_req, lk_addr); end
    do_lookup(1, 1, 0);
    tests++; if (cr_valid !== 1'b1 || cr_resp !== 5'b11101) begin fails++; $display("FAIL rs_resp got %b/%b exp 1/11101", cr_valid, cr_resp); end
    cr_ready = 1;
    tick();
    cr_ready = 0;
    tests++; if (cd_valid !== 1'b1 || cd_data !== first || cd_last !== 1'b0) begin fails++; $display("FAIL rs_beat0 got %b/%h/%b exp 1/%h/0", cd_valid, cd_data, cd_last, first); end
    cd_ready = 1;
    tick();
    tests++; if (cd_valid !== 1'b1 || cd_data !== second || cd_last !== 1'b1) begin fails++; $display("FAIL rs_beat1 got %b/%h/%b exp 1/%h/1", cd_valid, cd_data, cd_last, second); end
    tick();
    cd_ready = 0;
    tests++; if (cd_valid !== 1'b0 || ac_ready !== 1'b1) begin fails++; $display("FAIL rs_done got %b/%b exp 0/1", cd_valid, ac_ready); end
  endtask

  task automatic test_read_unique_miss();
    send_ac(64'h40, 4'b0111);
    tests++; if ({lk_req, lk_inv, lk_clean} !== 3'b110) begin fails++; $display("FAIL ru_ctl got %b exp 110", {lk_req, lk_inv, lk_clean}); end
    do_lookup(0, 1, 0);
    tests++; if (cr_valid !== 1'b1 || cr_resp !== 5'b0) begin fails++; $display("FAIL ru_resp got %b/%b exp 1/00000", cr_valid, cr_resp); end
    cr_ready = 1;
    tick();
    cr_ready = 0;
    tests++; if (cd_valid !== 1'b0 || ac_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL ru_idle got %b/%b/%b exp 0/1/0", cd_valid, ac_ready, busy); end
  endtask

  task automatic test_clean_invalid();
    send_ac(64'h1234, 4'b1001);
    tests++; if ({lk_req, lk_inv, lk_clean} !== 3'b110) begin fails++; $display("FAIL ci_ctl got %b exp 110", {lk_req, lk_inv, lk_clean}); end
    do_lookup(1, 0, 1);
    tests++; if (cr_valid !== 1'b1 || cr_resp !== 5'b0) begin fails++; $display("FAIL ci_resp got %b/%b exp 1/00000", cr_valid, cr_resp); end
    cr_ready = 1;
    tick();
    cr_ready = 0;
    tests++; if (cd_valid !== 1'b0 || ac_ready !== 1'b1) begin fails++; $display("FAIL ci_nodata got %b/%b exp 0/1", cd_valid, ac_ready); end
  endtask

  task automatic test_unsupported();
    lk_hit = 1; lk_dirty = 1;
    send_ac(64'h80, 4'b1111);
    tests++; if (lk_req !== 1'b0 || cr_valid !== 1'b1 || cr_resp !== 5'b0 || busy !== 1'b1) begin fails++; $display("FAIL unsup got %b/%b/%b/%b exp 0/1/00000/1", lk_req, cr_valid, cr_resp, busy); end
    cr_ready = 1;
    tick();
    cr_ready = 0;
    tests++; if (ac_ready !== 1'b1 || cd_valid !== 1'b0) begin fails++; $display("FAIL unsup_done got %b/%b exp 1/0", ac_ready, cd_valid); end
  endtask

  task automatic test_read_once_stall();
    int hs = 0;
    send_ac(64'h100, 4'b0000);
    tests++; if ({lk_req, lk_inv, lk_clean} !== 3'b100) begin fails++; $display("FAIL ro_ctl got %b exp 100", {lk_req, lk_inv, lk_clean}); end
    do_lookup(1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tests++; if (cr_valid !== 1'b1 || cr_resp !== 5'b11001 || ac_ready !== 1'b0) begin fails++; $display("FAIL ro_stall%0d got %b/%b/%b exp 1/11001/0", i, cr_valid, cr_resp, ac_ready); end
      tick();
    end
    cr_ready = 1;
    tick();
    cr_ready = 0;
    for (int i = 0; i < 10; i++) begin
      cd_ready = i[0];
      if (cd_valid && cd_ready) begin
        tests++; if (cd_data !== (hs == 0 ? LO : HI) || cd_last !== (hs == 1)) begin fails++; $display("FAIL ro_beat%0d got %h/%b", hs, cd_data, cd_last); end
        hs++;
      end
      tests++; if (ac_ready !== 1'b0) begin fails++; $display("FAIL ro_ready_early got %b exp 0", ac_ready); end
      tick();
      if (!busy) break;
    end
    cd_ready = 0;
    tests++; if (hs !== 2 || ac_ready !== 1'b1) begin fails++; $display("FAIL ro_handshakes got %0d/%b exp 2/1", hs, ac_ready); end
  endtask

  task automatic test_reset_mid_data();
    send_ac(64'h200, 4'b0001);
    do_lookup(1, 1, 0);
    cr_ready = 1;
    tick();
    cr_ready = 0; cd_ready = 1;
    tick();
    cd_ready = 0;
    tests++; if (cd_valid !== 1'b1 || cd_last !== 1'b1) begin fails++; $display("FAIL mr_beat1 got %b/%b exp 1/1", cd_valid, cd_last); end
    rst = 1;
    tick();
    tests++; if ({ac_ready, cr_valid, cd_valid, cd_last, lk_req, lk_inv, lk_clean, busy} !== 8'b0 || cr_resp !== 5'b0 || cd_data !== 64'b0 || lk_addr !== 64'b0) begin fails++; $display("FAIL mr_outputs got %b/%b/%h/%h exp zeros", {ac_ready, cr_valid, cd_valid, cd_last, lk_req, lk_inv, lk_clean, busy}, cr_resp, cd_data, lk_addr); end
    rst = 0;
    #1;
    tests++; if (ac_ready !== 1'b1) begin fails++; $display("FAIL mr_ready got %b exp 1", ac_ready); end
    tick();
    tests++; if (cr_valid !== 1'b0 || cd_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL mr_nocompletion got %b/%b/%b exp 0/0/0", cr_valid, cd_valid, busy); end
  endtask

  initial begin
    test_reset();
    test_read_shared();
    test_read_unique_miss();
    test_clean_invalid();
    test_unsupported();
    test_read_once_stall();
    test_reset_mid_data();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
